cordic_sincos_iter: RTL

Parametrised iterative CORDIC sine/cosine engine, the successor to the fixed 16-bit rotator. It generalises angle width, datapath width and iteration count, and adds full-circle quadrant correction, a valid/ready handshake on input and output, and output hold under backpressure. It sits between angle generators (phase accumulators, sequence generators) and downstream consumers that need Q2.F sine/cosine pairs.

---
 rtl/cordic_sincos_iter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative CORDIC sine/cosine engine.
// An unsigned phase angle (0..2^WIDTH-1 = 0..2pi) is folded into
// [-pi/2, pi/2) and rotated by ITER micro-rotations, one per cycle.
// The result is a Q2.(DATA_W-2) cosine/sine pair that is held until the
// consumer takes it.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE.
// Both come straight from the state register. Once out_valid is high,
// cosine/sine stay fixed until the handshake.
// Optional build macro: CORDIC_ROUND_EN adds round-half-up to the x/y shifts.
module cordic_sincos_iter #(
   parameter int WIDTH  = 16,
   parameter int DATA_W = 18,
   parameter int ITER   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         angle,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] cosine,
   output logic signed [DATA_W-1:0] sine
);

   // The iteration counter runs 0..ITER. The value ITER marks the result-register cycle.
   localparam int IW = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      DONE = 2'd2
   } state_t;

   // atan(2^-i) scaled so that 2^32 is a full circle.
   localparam logic [31:0] ATAN32 [32] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   // CORDIC gain compensation 0.6072529350, rounded to the Q2 datapath.
   localparam logic signed [DATA_W-1:0] K_INIT =
      DATA_W'((64'h9B74EDA8 + ((64'd1 << 33) >> DATA_W)) >> (34 - DATA_W));

   // Rescale a 32-bit table entry to WIDTH bits with round-to-nearest.
   function automatic logic [WIDTH-1:0] atan_round(input int idx);
      logic [32:0] t;
      t = ({1'b0, ATAN32[idx]} + ((33'd1 << 32) >> (WIDTH + 1))) >> (32 - WIDTH);
      return t[WIDTH-1:0];
   endfunction

   // Arithmetic right shift. It can optionally round half-up using the last bit shifted out.
   function automatic logic signed [DATA_W-1:0] shr(input logic signed [DATA_W-1:0] v,
                                                    input logic [IW-1:0] s);
      logic signed [DATA_W-1:0] r;
      r = v >>> s;
`ifdef CORDIC_ROUND_EN
      if (s != '0) r = r + $signed({{(DATA_W-1){1'b0}}, v[s - 1'b1]});
`endif
      return r;
   endfunction

   logic [WIDTH-1:0] atan_lut [2**IW];

   for (genvar k = 0; k < 2**IW; k++) begin : g_atan
      if (k < ITER) begin : g_used
         localparam logic [WIDTH-1:0] ATAN_K = atan_round(k);
         assign atan_lut[k] = ATAN_K;
      end else begin : g_pad
         assign atan_lut[k] = '0;
      end
   end

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  x_q, x_d, y_q, y_d;
   logic signed [DATA_W-1:0]  x_sh, y_sh;
   logic signed [WIDTH-1:0]   z_q, z_d;
   logic [IW-1:0]             i_q, i_d;
   logic                      neg_q, neg_d;
   logic                      fold;
   logic signed [DATA_W-1:0]  cos_q, cos_d, sin_q, sin_d;

   // State and datapath registers. An asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         neg_q   <= 1'b0;
         cos_q   <= '0;
         sin_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         neg_q   <= neg_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
      end
   end

   // Next state: capture and fold in IDLE, one micro-rotation per ROT cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      neg_d   = neg_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      fold    = angle[WIDTH-1] ^ angle[WIDTH-2];
      x_sh    = shr(x_q, i_q);
      y_sh    = shr(y_q, i_q);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Quadrants 2 and 3 rotate by angle-pi. The result is negated afterwards.
               neg_d   = fold;
               z_d     = fold ? $signed(angle ^ {1'b1, {(WIDTH-1){1'b0}}}) : $signed(angle);
               x_d     = K_INIT;
               y_d     = '0;
               i_d     = '0;
               state_d = ROT;
            end
         end
         ROT: begin
            if (i_q == IW'(ITER)) begin
               cos_d   = neg_q ? -x_q : x_q;
               sin_d   = neg_q ? -y_q : y_q;
               state_d = DONE;
            end else begin
               if (z_q[WIDTH-1]) begin
                  x_d = x_q + y_sh;
                  y_d = y_q - x_sh;
                  z_d = z_q + atan_lut[i_q];
               end else begin
                  x_d = x_q - y_sh;
                  y_d = y_q + x_sh;
                  z_d = z_q - atan_lut[i_q];
               end
               i_d = i_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign cosine    = cos_q;
   assign sine      = sin_q;

endmodule
